// File: rtl/module_bcd_binario.sv
`default_nettype none
// ============================================================================
// Module      : module_bcd_binario
// Description : Sequential BCD-to-binary converter, Horner accumulation, one
//               digit per clock, MSD first. Optional macro BCD_VALIDA_EN
//               rejects digits above 9 with a one-cycle listo+error response.
// Revision    : 1.0 - initial release
// ============================================================================
module module_bcd_binario #(
    parameter int NUM_DIGITOS  = 4,
    parameter int ANCHO_SALIDA = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inicio,
    input  logic [4*NUM_DIGITOS-1:0] digitos_input,
    output logic [ANCHO_SALIDA-1:0]  numero_output,
    output logic                     ocupado,
    output logic                     listo,
    output logic                     error
);

    localparam int c_ancho_digitos = 4 * NUM_DIGITOS;
    localparam int c_ancho_cnt     = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam logic [c_ancho_cnt-1:0] c_ultimo = c_ancho_cnt'(NUM_DIGITOS - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        ACUMULA = 1'b1
    } estado_t;

    estado_t                    r_estado;
    logic [c_ancho_digitos-1:0] r_digitos;
    logic [ANCHO_SALIDA-1:0]    r_acc;
    logic [c_ancho_cnt-1:0]     r_cnt;

    logic [3:0]                 w_digito_top;
    logic [ANCHO_SALIDA-1:0]    w_acc_sig;
    logic                       w_arranca;

    assign w_digito_top = r_digitos[c_ancho_digitos-1 -: 4];
    // acc*10 as (acc<<3)+(acc<<1); overflow wraps at ANCHO_SALIDA bits
    assign w_acc_sig    = (r_acc << 3) + (r_acc << 1) + ANCHO_SALIDA'(w_digito_top);

`ifdef BCD_VALIDA_EN
    logic [NUM_DIGITOS-1:0] w_digito_malo;
    logic                   w_hay_invalido;
    logic                   r_pendiente;
    logic                   r_error;

    for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_valida
        assign w_digito_malo[i] = (digitos_input[4*i +: 4] > 4'd9);
    end

    assign w_hay_invalido = |w_digito_malo;
    assign w_arranca      = inicio && !r_pendiente && !w_hay_invalido;
    assign error          = r_error;
`else
    assign w_arranca      = inicio;
    assign error          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado      <= IDLE;
            r_digitos     <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            numero_output <= '0;
            ocupado       <= 1'b0;
            listo         <= 1'b0;
`ifdef BCD_VALIDA_EN
            r_pendiente   <= 1'b0;
            r_error       <= 1'b0;
`endif
        end else begin
            case (r_estado)
                IDLE: begin
                    listo <= 1'b0;
`ifdef BCD_VALIDA_EN
                    // A rejected request answers on the following edge
                    r_error     <= r_pendiente;
                    r_pendiente <= inicio && !r_pendiente && w_hay_invalido;
                    if (r_pendiente) begin
                        listo         <= 1'b1;
                        numero_output <= '0;
                    end
`endif
                    if (w_arranca) begin
                        r_digitos <= digitos_input;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        ocupado   <= 1'b1;
                        r_estado  <= ACUMULA;
                    end
                end

                ACUMULA: begin
                    r_acc     <= w_acc_sig;
                    r_digitos <= r_digitos << 4;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_ultimo) begin
                        numero_output <= w_acc_sig;
                        listo         <= 1'b1;
                        ocupado       <= 1'b0;
                        r_estado      <= IDLE;
                    end
                end

                default: begin
                    r_estado <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/module_bcd_binario.md
Name: module_bcd_binario

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's binary-to-BCD divisor.
- Accepts NUM_DIGITOS packed BCD digits, most significant digit first, from keypad/display logic.
- Produces the unsigned binary value using Horner accumulation (acc = acc*10 + digit), one digit per clock.
- Sits between digit-entry logic and the arithmetic datapath; signals completion with a one-cycle listo pulse.

Parameters:
- NUM_DIGITOS, 4, number of BCD digits converted per request (≥1).
- ANCHO_SALIDA, 16, width of binary result; results wrap modulo 2^ANCHO_SALIDA.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- inicio  input  1  start request, sampled on the rising edge in IDLE.
- digitos_input  input  4*NUM_DIGITOS  packed BCD; bits [4*NUM_DIGITOS-1 -: 4] = most significant digit (millares for default).
- numero_output  output  ANCHO_SALIDA  binary result, registered.
- ocupado  output  1  high while a conversion is in progress.
- listo  output  1  one-cycle completion pulse.
- error  output  1  invalid-digit flag, valid with listo (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - numero_output=0, listo=0, ocupado=0, error=0.
  - Internal accumulator, digit shift register and digit counter cleared; state=IDLE.
  - Reset during a conversion aborts it; no listo is produced for the aborted request.
- States: IDLE, ACUMULA.
- IDLE:
  - listo, error deasserted unless set on this edge.
  - On inicio=1: latch digitos_input into the shift register, acc=0, cnt=0, ocupado<=1, state<=ACUMULA.
  - inicio=0: remain in IDLE.
- ACUMULA (one edge per digit):
  - acc <= (acc<<3)+(acc<<1)+digit_top, zero-extended to ANCHO_SALIDA, truncated on overflow.
  - Shift the register left by 4 bits; cnt <= cnt+1.
  - On the edge where cnt==NUM_DIGITOS-1:
    - numero_output <= final accumulated value.
    - listo <= 1 for exactly one cycle; ocupado <= 0.
    - state <= IDLE.
- Latency: for the edge E that accepts inicio, listo is high during the cycle following edge E+NUM_DIGITOS. Default case: 4 clocks from acceptance to the listo edge.
- ocupado is high from edge E through edge E+NUM_DIGITOS (exclusive of the listo cycle).
- inicio while ocupado=1: ignored. No queuing; latched digits are unaffected.
- digitos_input may change freely after the accepting edge.
- Back-to-back operation: inicio=1 in the listo cycle (state IDLE) is accepted. The new conversion starts with no bubble; listo drops the next cycle.
- numero_output holds its last value until the next completion or reset.
- Width rule: internal accumulator is ANCHO_SALIDA bits; products and sums beyond the width wrap silently.

Optional Feature:
- Macro: BCD_VALIDA_EN.
- Defined:
  - In IDLE, on an accepted inicio, every latched digit is checked.
  - If any digit > 9: no accumulation, state stays IDLE, ocupado stays 0. Next edge sets listo=1, error=1, numero_output=0 (1-cycle latency).
  - Valid inputs: error=0 with listo.
- Not defined:
  - error is tied to 0.
  - Digits 10–15 are used as plain 4-bit binary weights in the Horner sum.
  - Latency is always NUM_DIGITOS.

Test Plan:
- Basic conversion: digitos=16'h1234, inicio pulse → listo exactly 4 cycles after acceptance, numero_output=16'h04D2, ocupado high for the 4 preceding cycles, error=0.
- Extremes: 16'h9999 → 16'h270F; 16'h0000 → 16'h0000. Each listo is one cycle wide, and numero_output holds afterwards.
- Busy handling: 16'h0042 started; inicio held with 16'h0777 while ocupado → single listo with 16'h002A. Back-to-back inicio in the listo cycle with 16'h0777 → second listo 4 cycles later, 16'h0309.
- Reset mid-conversion: start 16'h5678, drive rst=0 after 2 cycles → all outputs 0 immediately, no listo. After release, 16'h0001 converts to 16'h0001.
- Invalid digit 16'h1A23:
  - With BCD_VALIDA_EN: listo+error one cycle after acceptance, numero_output=0.
  - Without: listo after 4 cycles, numero_output=16'h07E7 (2023), error=0.
